// File: rtl/rw_mailbox_fifo.sv
// ---------------------------------------------------------------------------
// rw_mailbox_fifo
// Single-clock mailbox FIFO with a registered read port (latency 1),
// registered occupancy flags and sticky overflow/underflow error flags.
// Storage is read-before-write: a word written on an edge is not visible
// to a read accepted on that same edge.
// ---------------------------------------------------------------------------
module rw_mailbox_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf_err,
    output logic                     unf_err
);

    // Pointer width; DEPTH is a power of two, so pointers wrap naturally.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    // Storage and state
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]    count_q,    count_d;
    logic             full_q,     full_d;
    logic             empty_q,    empty_d;
    logic [WIDTH-1:0] rd_data_q,  rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             ovf_err_q,  ovf_err_d;
    logic             unf_err_q,  unf_err_d;

    // Handshake decisions for the current edge
    logic             rd_accept;
    logic             wr_accept;

    // Decide which requests are accepted this cycle.
    always_comb begin
        // A read needs data; a write needs room, or the slot freed by a
        // read accepted on the same edge.
        rd_accept = rd_en && !empty_q;
        wr_accept = wr_en && (!full_q || rd_accept);
    end

    // Next-state for pointers, occupancy, read port and error flags.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path leaves a variable unassigned and no latch is inferred.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        ovf_err_d  = ovf_err_q;
        unf_err_d  = unf_err_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        if (rd_accept) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            // mem_q still holds pre-edge contents here, which gives the
            // read-before-write behaviour when both pointers coincide.
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
        end

        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Overflow: a write that found no room and no simultaneous read.
        if (wr_en && full_q && !rd_accept) begin
            ovf_err_d = 1'b1;
        end

        // Underflow: any read request while empty, even alongside a write.
        if (rd_en && empty_q) begin
            unf_err_d = 1'b1;
        end

        // Flags are registered from the next count so they always agree
        // with the count output in the same cycle.
        full_d  = (count_d == COUNT_FULL);
        empty_d = (count_d == '0);
    end

    // Control and status registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_err_q  <= 1'b0;
            unf_err_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_err_q  <= ovf_err_d;
            unf_err_q  <= unf_err_d;
        end
    end

    // Storage write port; dropped writes never reach the array.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; after reset the
        // pointers and count make every stale entry unreachable.
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        rd_data  = rd_data_q;
        rd_valid = rd_valid_q;
        full     = full_q;
        empty    = empty_q;
        count    = count_q;
        ovf_err  = ovf_err_q;
        unf_err  = unf_err_q;
    end

endmodule

// File: tb/tb_rw_mailbox_fifo.sv
// ---------------------------------------------------------------------------
// tb_rw_mailbox_fifo
// Self-checking bench: a queue-based reference FIFO plus a scoreboard of
// expected read words, a table of hand-computed vectors, and hand-written
// sequences for same-edge, reset and wrap corner cases.
// ---------------------------------------------------------------------------
module tb_rw_mailbox_fifo;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             ovf_err;
    logic             unf_err;

    rw_mailbox_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .ovf_err  (ovf_err),
        .unf_err  (unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] sb_q    [$];
    logic [WIDTH-1:0] m_data;
    logic             m_ovf;
    logic             m_unf;

    typedef struct {
        logic             we;
        logic [WIDTH-1:0] wd;
        logic             re;
        logic             ev;
        logic [WIDTH-1:0] ed;
        logic [CW-1:0]    ec;
        logic             eo;
        logic             eu;
    } vec_t;

    vec_t vecs [29];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [WIDTH-1:0] wd, input logic re,
                                input logic ev, input logic [WIDTH-1:0] ed,
                                input logic [CW-1:0] ec, input logic eo, input logic eu);
        vec_t v;
        v.we = we; v.wd = wd; v.re = re;
        v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo; v.eu = eu;
        return v;
    endfunction

    // Async reset pulse taken between edges; outputs checked before any edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_q.delete();
        sb_q.delete();
        m_data = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        check("rst_rd_data",  rd_data,  0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_count",    count,    0);
        check("rst_empty",    empty,    1);
        check("rst_full",     full,     0);
        check("rst_ovf",      ovf_err,  0);
        check("rst_unf",      unf_err,  0);
        #1;
        rst = 1'b0;
    endtask

    // One clock of stimulus; model predicts, scoreboard checks read words.
    task automatic step(input logic we, input logic [WIDTH-1:0] wd, input logic re);
        logic racc;
        logic wacc;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        racc = re && (model_q.size() > 0);
        wacc = we && ((model_q.size() < DEPTH) || racc);
        if (we && (model_q.size() == DEPTH) && !racc) m_ovf = 1'b1;
        if (re && (model_q.size() == 0))              m_unf = 1'b1;
        if (racc) begin
            m_data = model_q.pop_front();
            sb_q.push_back(m_data);
        end
        if (wacc) model_q.push_back(wd);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("rd_valid", rd_valid, racc);
        if (rd_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=rd_valid=1 required=no read pending at %0t", $time);
            end else begin
                check("sb_word", rd_data, sb_q.pop_front());
            end
        end else begin
            sb_q.delete();
        end
        check("rd_data_hold", rd_data, m_data);
        check("count",   count,   model_q.size());
        check("full",    full,    model_q.size() == DEPTH);
        check("empty",   empty,   model_q.size() == 0);
        check("ovf_err", ovf_err, m_ovf);
        check("unf_err", unf_err, m_unf);
    endtask

    initial begin
        // Hand-computed vectors: {we, wd, re} -> {valid, data, count, ovf, unf}
        // Fill 9,3,A,5 then drain in order.
        vecs[0]  = mk(1, 4'h9, 0, 0, 4'h0, 1, 0, 0);
        vecs[1]  = mk(1, 4'h3, 0, 0, 4'h0, 2, 0, 0);
        vecs[2]  = mk(1, 4'hA, 0, 0, 4'h0, 3, 0, 0);
        vecs[3]  = mk(1, 4'h5, 0, 0, 4'h0, 4, 0, 0);
        vecs[4]  = mk(0, 4'h0, 1, 1, 4'h9, 3, 0, 0);
        vecs[5]  = mk(0, 4'h0, 1, 1, 4'h3, 2, 0, 0);
        vecs[6]  = mk(0, 4'h0, 1, 1, 4'hA, 1, 0, 0);
        vecs[7]  = mk(0, 4'h0, 1, 1, 4'h5, 0, 0, 0);
        vecs[8]  = mk(0, 4'h0, 0, 0, 4'h5, 0, 0, 0);
        // Full plus simultaneous write F and read.
        vecs[9]  = mk(1, 4'h1, 0, 0, 4'h5, 1, 0, 0);
        vecs[10] = mk(1, 4'h2, 0, 0, 4'h5, 2, 0, 0);
        vecs[11] = mk(1, 4'h3, 0, 0, 4'h5, 3, 0, 0);
        vecs[12] = mk(1, 4'h4, 0, 0, 4'h5, 4, 0, 0);
        vecs[13] = mk(1, 4'hF, 1, 1, 4'h1, 4, 0, 0);
        vecs[14] = mk(0, 4'h0, 1, 1, 4'h2, 3, 0, 0);
        vecs[15] = mk(0, 4'h0, 1, 1, 4'h3, 2, 0, 0);
        vecs[16] = mk(0, 4'h0, 1, 1, 4'h4, 1, 0, 0);
        vecs[17] = mk(0, 4'h0, 1, 1, 4'hF, 0, 0, 0);
        // Full, lone write 7 is dropped and sets ovf_err.
        vecs[18] = mk(1, 4'h1, 0, 0, 4'hF, 1, 0, 0);
        vecs[19] = mk(1, 4'h2, 0, 0, 4'hF, 2, 0, 0);
        vecs[20] = mk(1, 4'h3, 0, 0, 4'hF, 3, 0, 0);
        vecs[21] = mk(1, 4'h4, 0, 0, 4'hF, 4, 0, 0);
        vecs[22] = mk(1, 4'h7, 0, 0, 4'hF, 4, 1, 0);
        vecs[23] = mk(0, 4'h0, 1, 1, 4'h1, 3, 1, 0);
        vecs[24] = mk(0, 4'h0, 1, 1, 4'h2, 2, 1, 0);
        vecs[25] = mk(0, 4'h0, 1, 1, 4'h3, 1, 1, 0);
        vecs[26] = mk(0, 4'h0, 1, 1, 4'h4, 0, 1, 0);
        vecs[27] = mk(0, 4'h0, 0, 0, 4'h4, 0, 1, 0);
        // Read on empty: rd_data held, unf_err set.
        vecs[28] = mk(0, 4'h0, 1, 0, 4'h4, 0, 1, 1);

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        m_data  = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;

        // Reset state, then release between edges.
        @(posedge clk);
        #1;
        do_reset();

        // Table-driven vectors
        for (int i = 0; i < 29; i++) begin
            step(vecs[i].we, vecs[i].wd, vecs[i].re);
            check("tbl_valid", rd_valid, vecs[i].ev);
            check("tbl_data",  rd_data,  vecs[i].ed);
            check("tbl_count", count,    vecs[i].ec);
            check("tbl_full",  full,     vecs[i].ec == CW'(DEPTH));
            check("tbl_empty", empty,    vecs[i].ec == '0);
            check("tbl_ovf",   ovf_err,  vecs[i].eo);
            check("tbl_unf",   unf_err,  vecs[i].eu);
        end

        // Write and read on the same edge from empty.
        do_reset();
        step(1, 4'h9, 1);
        check("same_edge_valid", rd_valid, 0);
        check("same_edge_unf",   unf_err,  1);
        check("same_edge_count", count,    1);
        step(0, 4'h0, 1);
        check("same_edge_data",  rd_data,  4'h9);
        check("same_edge_vld2",  rd_valid, 1);

        // Ten words through alternating writes and reads; pointers wrap.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1, i[WIDTH-1:0], 0);
            step(0, 4'h0, 1);
            check("wrap_order", rd_data, i[WIDTH-1:0]);
        end
        // Same ten words with two in flight, mixing same-edge write/read.
        step(1, 4'h0, 0);
        for (int i = 1; i < 10; i++) begin
            step(1, i[WIDTH-1:0], 1);
            check("wrap2_order", rd_data, i - 1);
        end
        step(0, 4'h0, 1);
        check("wrap2_last", rd_data, 4'h9);

        // Reset mid-operation with two words stored and a read in flight.
        do_reset();
        step(1, 4'hA, 0);
        step(1, 4'hB, 0);
        step(1, 4'hC, 0);
        step(0, 4'h0, 1);
        check("mid_pre_count", count, 2);
        do_reset();
        step(0, 4'h0, 1);
        check("mid_post_unf",   unf_err,  1);
        check("mid_post_valid", rd_valid, 0);
        step(1, 4'h6, 0);
        step(0, 4'h0, 1);
        check("mid_post_data",  rd_data,  4'h6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rw_mailbox_fifo.md
RW_MAILBOX_FIFO -- requirements
Module: rw_mailbox_fifo

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, data word width in bits.
REQ-002 SHALL provide parameter DEPTH, default 4, number of entries; power of two, minimum 2.
REQ-003 SHALL provide port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-004 SHALL provide port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL provide port wr_en, input, 1 bit: write request.
REQ-006 SHALL provide port wr_data, input, WIDTH bits: write word.
REQ-007 SHALL provide port rd_en, input, 1 bit: read request.
REQ-008 SHALL provide port rd_data, output, WIDTH bits: registered read word.
REQ-009 SHALL provide port rd_valid, output, 1 bit: rd_data updated this cycle.
REQ-010 SHALL provide ports full and empty, output, 1 bit each: occupancy flags.
REQ-011 SHALL provide port count, output, log2(DEPTH)+1 bits: entries held.
REQ-012 SHALL provide ports ovf_err and unf_err, output, 1 bit each: sticky error flags.

Function
REQ-013 SHALL accept a write when wr_en=1 and (full=0 or a read is accepted in the same cycle); store wr_data at wr_ptr; increment wr_ptr.
REQ-014 SHALL accept a read when rd_en=1 and empty=0; load rd_data from rd_ptr on that clock edge; increment rd_ptr.
REQ-015 SHALL have read latency 1: rd_data and rd_valid=1 visible in the cycle after the rd_en edge; rd_valid=0 in every cycle not following an accepted read.
REQ-016 SHALL hold rd_data at its last value when no read is accepted.
REQ-017 SHALL return, for the same edge, storage contents as they were before that edge (read-before-write); a word written on edge N is readable no earlier than edge N+1.
REQ-018 SHALL wrap wr_ptr and rd_ptr from DEPTH-1 to 0 with no gap or skipped entry.
REQ-019 SHALL update count: +1 on write only, -1 on read only, unchanged on both or neither; full=(count==DEPTH), empty=(count==0), all registered-consistent in the same cycle.
REQ-020 SHALL, when empty and wr_en=rd_en=1, accept the write, reject the read (rd_valid=0 next cycle), and set unf_err.
REQ-021 SHALL, when full and wr_en=rd_en=1, accept both; count stays DEPTH, ovf_err unchanged.
REQ-022 SHALL, on wr_en=1 with full=1 and no accepted read, drop the word, leave storage and wr_ptr unchanged, and set ovf_err.
REQ-023 SHALL, on rd_en=1 with empty=1, leave rd_ptr and rd_data unchanged and set unf_err.
REQ-024 SHALL keep ovf_err and unf_err set until reset.

Reset
REQ-025 SHALL, on rst=1, immediately and regardless of clk, clear wr_ptr, rd_ptr, count, rd_data=0, rd_valid=0, ovf_err=0, unf_err=0, empty=1, full=0.
REQ-026 SHALL not require storage array contents to be cleared; stale entries are unreachable after reset.
REQ-027 SHALL, on reset asserted mid-operation, discard all stored words and any read in flight; first edge after rst=0 behaves as from empty.

Verification
REQ-028 Reset then write 9,3,A,5 on consecutive edges -> full=1, count=4; read 4 times -> rd_data 9,3,A,5 on the cycles after each read, rd_valid=1 each, empty=1 at end.
REQ-029 Write 9 and rd_en on same edge from empty -> rd_valid=0 next cycle, unf_err=1, count=1; next read -> rd_data=9.
REQ-030 Full with 1,2,3,4, wr_en=1 wr_data=F plus rd_en=1 -> rd_data=1, count=4, ovf_err=0; drain -> 2,3,4,F.
REQ-031 Full, wr_en=1 wr_data=7 alone -> ovf_err=1, count=4; drain -> original four words, no 7.
REQ-032 Push/pop 10 words 0..9 through interleaved single writes/reads -> pointers wrap, output order 0..9 exact.
REQ-033 Two words stored, rst pulsed between edges -> count=0, empty=1, rd_data=0 immediately; next rd_en -> unf_err=1, rd_valid=0.
